// File: rtl/serial_parity_checker.sv
// Serial frame receiver: DATA_BITS data bits (LSB first) plus one parity bit.
// Reassembles the word and flags a parity mismatch once per completed frame.
module serial_parity_checker #(
   parameter int DATA_BITS  = 8,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 bit_in,
   input  logic                 bit_valid,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 parity_err,
   output logic [DATA_BITS-1:0] data_out
);

   // state  | meaning
   // IDLE   | waiting for start; outputs hold the last completed frame
   // DATA   | collecting DATA_BITS data bits, LSB first
   // PARITY | waiting for the parity bit that closes the frame
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2
   } state_t;

   localparam int          CW       = $clog2(DATA_BITS);
   localparam logic [CW-1:0] LAST_CNT = CW'(DATA_BITS - 1);

   state_t               state;
   logic [CW-1:0]        cnt;
   logic                 acc;
   logic [DATA_BITS-1:0] shreg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         acc        <= 1'b0;
         shreg      <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         parity_err <= 1'b0;
         data_out   <= '0;
      end else begin
         frame_done <= 1'b0;
         // abort wins over everything; the last completed result stays visible
         if (abort) begin
            state <= S_IDLE;
            cnt   <= '0;
            acc   <= 1'b0;
            busy  <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     state <= S_DATA;
                     cnt   <= '0;
                     acc   <= 1'b0;
                     shreg <= '0;
                     busy  <= 1'b1;
                  end
               end
               S_DATA: begin
                  if (bit_valid) begin
                     shreg[cnt] <= bit_in;
                     acc        <= acc ^ bit_in;
                     cnt        <= cnt + CW'(1);
                     if (cnt == LAST_CNT) begin
                        state <= S_PARITY;
                     end
                  end
               end
               S_PARITY: begin
                  if (bit_valid) begin
                     parity_err <= acc ^ bit_in ^ PARITY_ODD;
                     data_out   <= shreg;
                     frame_done <= 1'b1;
                     state      <= S_IDLE;
                     busy       <= 1'b0;
                  end
               end
               default: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
